// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter.
// Drives open-drain CLK/DAT through inhibit, RTS, bit transfer and ACK check.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int SETUP_CYCLES   = 1000,
  parameter int START_TIMEOUT  = 750000,
  parameter int PKT_TIMEOUT    = 100000
) (
  input  logic       CLOCK_50,
  input  logic       Resetn,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT,
  input  logic       send_req,
  input  logic [7:0] send_data,
  output logic       busy,
  output logic       tx_active,
  output logic       done,
  output logic [1:0] err_code
);

  localparam int M1 = (INHIBIT_CYCLES > SETUP_CYCLES) ?
                      INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int M2 = (START_TIMEOUT > PKT_TIMEOUT) ?
                      START_TIMEOUT : PKT_TIMEOUT;
  localparam int MX = (M1 > M2) ? M1 : M2;
  localparam int TW = $clog2(MX + 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, RTS, WAIT_FIRST, SEND, ACK, RELEASE
  } state_t;

  state_t      state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [9:0]  frame, frame_n;
  logic [3:0]  bit_cnt, bit_cnt_n;
  logic        clk_low, clk_low_n;
  logic        dat_low, dat_low_n;
  logic        done_n;
  logic [1:0]  err_n;
  logic        clk_s1, clk_s2, clk_prev;
  logic        dat_s1, dat_s2;
  logic        fe, pkt_to;

  assign PS2_CLK   = clk_low ? 1'b0 : 1'bz;
  assign PS2_DAT   = dat_low ? 1'b0 : 1'bz;
  assign busy      = (state != IDLE);
  assign tx_active = busy;
  assign fe        = clk_prev & ~clk_s2;
  assign pkt_to    = (timer == TW'(PKT_TIMEOUT - 1));

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= PS2_CLK;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= PS2_DAT;
      dat_s2   <= dat_s1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      state    <= IDLE;
      timer    <= '0;
      frame    <= '0;
      bit_cnt  <= '0;
      clk_low  <= 1'b0;
      dat_low  <= 1'b0;
      done     <= 1'b0;
      err_code <= 2'b00;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      frame    <= frame_n;
      bit_cnt  <= bit_cnt_n;
      clk_low  <= clk_low_n;
      dat_low  <= dat_low_n;
      done     <= done_n;
      err_code <= err_n;
    end
  end

  always_comb begin
    state_n   = state;
    timer_n   = timer + 1'b1;
    frame_n   = frame;
    bit_cnt_n = bit_cnt;
    clk_low_n = 1'b0;
    dat_low_n = dat_low;
    done_n    = 1'b0;
    err_n     = err_code;
    unique case (state)
      IDLE: begin
        timer_n   = '0;
        dat_low_n = 1'b0;
        if (send_req && !done) begin
          frame_n   = {1'b1, ~^send_data, send_data};
          bit_cnt_n = '0;
          clk_low_n = 1'b1;
          state_n   = INHIBIT;
        end
      end
      INHIBIT: begin
        clk_low_n = 1'b1;
        dat_low_n = 1'b0;
        if (timer == TW'(INHIBIT_CYCLES - 1)) begin
          dat_low_n = 1'b1;
          timer_n   = '0;
          state_n   = RTS;
        end
      end
      RTS: begin
        clk_low_n = 1'b1;
        dat_low_n = 1'b1;
        if (timer == TW'(SETUP_CYCLES - 1)) begin
          clk_low_n = 1'b0;
          timer_n   = '0;
          state_n   = WAIT_FIRST;
        end
      end
      WAIT_FIRST: begin
        dat_low_n = 1'b1;
        if (fe) begin
          dat_low_n = ~frame[0];
          frame_n   = frame >> 1;
          bit_cnt_n = 4'd1;
          timer_n   = '0;
          state_n   = SEND;
        end else if (timer == TW'(START_TIMEOUT - 1)) begin
          state_n = IDLE;
        end
      end
      SEND: begin
        if (pkt_to) begin
          state_n = IDLE;
        end else if (fe) begin
          dat_low_n = ~frame[0];
          frame_n   = frame >> 1;
          bit_cnt_n = bit_cnt + 4'd1;
          // stop bit is a 1, so the line is released from here on
          if (bit_cnt == 4'd9) begin
            dat_low_n = 1'b0;
            state_n   = ACK;
          end
        end
      end
      ACK: begin
        dat_low_n = 1'b0;
        if (pkt_to) begin
          state_n = IDLE;
        end else if (fe) begin
          err_n   = dat_s2 ? 2'b01 : 2'b00;
          state_n = RELEASE;
        end
      end
      RELEASE: begin
        dat_low_n = 1'b0;
        if (pkt_to) begin
          state_n = IDLE;
        end else if (clk_s2 && dat_s2) begin
          done_n  = 1'b1;
          timer_n = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    // any timeout exit lands here: release lines and report 10
    if (state != IDLE && state_n == IDLE && !done_n) begin
      clk_low_n = 1'b0;
      dat_low_n = 1'b0;
      done_n    = 1'b1;
      err_n     = 2'b10;
      timer_n   = '0;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with a clock-generating device model.
// Expected frames and result codes are queued at issue time.
module tb_ps2_host_tx;

  localparam int INH  = 50;
  localparam int SET  = 10;
  localparam int STO  = 400;
  localparam int PTO  = 2000;
  localparam int HALF = 20;

  typedef enum int { M_ACK, M_NACK, M_SILENT, M_STOP4 } mode_t;

  logic       clk = 1'b0;
  logic       Resetn = 1'b0;
  logic       send_req = 1'b0;
  logic [7:0] send_data = 8'h00;
  logic       busy, tx_active, done;
  logic [1:0] err_code;
  wire        PS2_CLK, PS2_DAT;
  logic       dev_clk = 1'b0;
  logic       dev_dat = 1'b0;

  assign PS2_CLK = dev_clk ? 1'b0 : 1'bz;
  assign PS2_DAT = dev_dat ? 1'b0 : 1'bz;
  pullup (PS2_CLK);
  pullup (PS2_DAT);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH), .SETUP_CYCLES(SET),
    .START_TIMEOUT(STO), .PKT_TIMEOUT(PTO)
  ) dut (
    .CLOCK_50(clk), .Resetn(Resetn),
    .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT),
    .send_req(send_req), .send_data(send_data),
    .busy(busy), .tx_active(tx_active),
    .done(done), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int         vec = 0;
  int         miss = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  int         bfm_edges = 0;
  int         t_fe = 0;
  bit         abort = 1'b0;
  mode_t      mode_q[$];
  logic [1:0] exp_err_q[$];
  logic [7:0] exp_byte_q[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic hcyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic odd_par(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += d[i];
    return (ones % 2 == 0);
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // result monitor
  initial forever begin
    @(negedge clk);
    if (Resetn && done) begin
      done_cnt++;
      if (exp_err_q.size() == 0) begin
        chk("spurious_done", 32'(done_cnt), 32'(done_cnt - 1));
      end else begin
        chk("err_code", 32'(err_code), 32'(exp_err_q.pop_front()));
      end
      chk("busy_at_done", 32'(busy), 0);
      chk("tx_active_at_done", 32'(tx_active), 0);
    end
  end

  // device model: clocks the frame in and checks it
  initial begin : bfm
    mode_t      m;
    logic [9:0] rx;
    logic [7:0] eb;
    int         nb;
    forever begin
      @(negedge clk);
      if (Resetn && PS2_CLK === 1'b1 && PS2_DAT === 1'b0 &&
          mode_q.size() > 0) begin
        m = mode_q.pop_front();
        rx = '0;
        hcyc(10);
        if (m != M_SILENT) begin
          nb = (m == M_STOP4) ? 4 : 10;
          for (int i = 0; i < nb && !abort; i++) begin
            dev_clk = 1'b1;
            if (i == 0) t_fe = cyc;
            bfm_edges++;
            hcyc(HALF);
            dev_clk = 1'b0;
            rx[i] = PS2_DAT;
            hcyc(HALF);
          end
          if (nb == 10 && !abort) begin
            if (exp_byte_q.size() == 0) begin
              chk("unexpected_frame", 32'(rx), 0);
            end else begin
              eb = exp_byte_q.pop_front();
              chk("rx_data", 32'(rx[7:0]), 32'(eb));
              chk("rx_parity", 32'(rx[8]), 32'(odd_par(eb)));
              chk("rx_stop", 32'(rx[9]), 1);
            end
            dev_dat = (m == M_ACK);
            hcyc(5);
            dev_clk = 1'b1;
            hcyc(HALF);
            dev_clk = 1'b0;
            hcyc(10);
            dev_dat = 1'b0;
          end
        end
        if (abort) begin
          dev_clk = 1'b0;
          dev_dat = 1'b0;
          abort = 1'b0;
        end
      end
    end
  end

  task automatic start_tx(input logic [7:0] d, input mode_t m,
                          input bit expect_done);
    mode_q.push_back(m);
    if (expect_done) begin
      case (m)
        M_ACK:   exp_err_q.push_back(2'b00);
        M_NACK:  exp_err_q.push_back(2'b01);
        default: exp_err_q.push_back(2'b10);
      endcase
      if (m == M_ACK || m == M_NACK) exp_byte_q.push_back(d);
    end
    bfm_edges = 0;
    @(negedge clk);
    send_req = 1'b1;
    send_data = d;
    @(negedge clk);
    send_req = 1'b0;
    send_data = $urandom;
    chk("busy_rise", 32'(busy), 1);
  endtask

  // ends on the cycle PS2_CLK is released
  task automatic measure();
    int n = 0;
    while (PS2_CLK === 1'b0 && PS2_DAT === 1'b1 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk("inhibit_len", 32'(n), INH);
    n = 0;
    while (PS2_CLK === 1'b0 && PS2_DAT === 1'b0 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk("setup_len", 32'(n), SET);
    chk("rts_clk_released", 32'(PS2_CLK), 1);
    chk("rts_dat_low", 32'(PS2_DAT), 0);
  endtask

  task automatic wait_done(input int bound, output int n);
    n = 0;
    while (!done && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 32'(n), 32'(bound + 1));
  endtask

  initial begin
    int n, d0, w;
    mode_t m;
    logic [7:0] b;
    repeat (4) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err_code), 0);
    chk("rst_clk", 32'(PS2_CLK), 1);
    chk("rst_dat", 32'(PS2_DAT), 1);
    Resetn = 1'b1;
    hcyc(5);

    start_tx(8'hED, M_ACK, 1);
    measure();
    wait_done(PTO, n);
    hcyc(20);

    start_tx(8'hF4, M_NACK, 1);
    measure();
    wait_done(PTO, n);
    hcyc(20);

    start_tx(8'h3C, M_SILENT, 1);
    measure();
    wait_done(STO + 50, n);
    chk("start_to_len", 32'(n), STO);
    chk("sto_clk_rel", 32'(PS2_CLK), 1);
    chk("sto_dat_rel", 32'(PS2_DAT), 1);
    hcyc(20);

    start_tx(8'hA7, M_STOP4, 1);
    measure();
    wait_done(PTO + 600, n);
    w = cyc - t_fe;
    chk("pkt_to_len", 32'(w >= PTO + 2 && w <= PTO + 4), 1);
    chk("pto_clk_rel", 32'(PS2_CLK), 1);
    chk("pto_dat_rel", 32'(PS2_DAT), 1);
    hcyc(20);

    d0 = done_cnt;
    start_tx(8'hED, M_ACK, 1);
    n = 0;
    while (bfm_edges < 3 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    send_req = 1'b1;
    send_data = 8'h55;
    @(negedge clk);
    send_req = 1'b0;
    wait_done(PTO, n);
    hcyc(200);
    chk("one_done", 32'(done_cnt - d0), 1);
    chk("idle_after", 32'(busy), 0);
    chk("no_extra_frame", 32'(exp_byte_q.size()), 0);

    d0 = done_cnt;
    start_tx(8'h99, M_ACK, 0);
    n = 0;
    while (!(bfm_edges >= 5 && dev_clk == 1'b0) && n < 2000) begin
      @(posedge clk);
      #2;
      n++;
    end
    abort = 1'b1;
    Resetn = 1'b0;
    #1;
    chk("rst_mid_clk", 32'(PS2_CLK), 1);
    chk("rst_mid_dat", 32'(PS2_DAT), 1);
    chk("rst_mid_busy", 32'(busy), 0);
    hcyc(3);
    Resetn = 1'b1;
    n = 0;
    while (abort && n < 200) begin
      @(negedge clk);
      n++;
    end
    hcyc(100);
    chk("rst_no_done", 32'(done_cnt - d0), 0);
    start_tx(8'hFF, M_ACK, 1);
    measure();
    wait_done(PTO, n);
    hcyc(20);

    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom);
      m = ($urandom_range(0, 1) == 1) ? M_NACK : M_ACK;
      start_tx(b, m, 1);
      measure();
      wait_done(PTO, n);
      hcyc($urandom_range(2, 30));
    end
    hcyc(50);
    chk("err_q_empty", 32'(exp_err_q.size()), 0);
    chk("byte_q_empty", 32'(exp_byte_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It sends one command byte (for example 0xED set-LEDs, 0xF4 enable, 0xFF reset) from the FPGA to the keyboard over the shared PS2_CLK/PS2_DAT open-drain lines. It is the companion to the existing scan-code shift receiver and handles the full host request sequence: inhibit, request-to-send, device-clocked bit transfer and acknowledge check. While active it asserts tx_active so the receiver path can ignore line activity.

Parameters:
INHIBIT_CYCLES, 6000, CLOCK_50 cycles that PS2_CLK is held low (120 us).
SETUP_CYCLES, 1000, cycles with both lines low before PS2_CLK is released (20 us).
START_TIMEOUT, 750000, maximum cycles from PS2_CLK release to the first device falling edge (15 ms).
PKT_TIMEOUT, 100000, maximum cycles from the first falling edge to the ACK falling edge (2 ms).

Ports:
CLOCK_50  input  1  system clock, 50 MHz
Resetn  input  1  asynchronous active-low reset
PS2_CLK  inout  1  open-drain; block drives 1'b0 or 1'bz only
PS2_DAT  inout  1  open-drain; block drives 1'b0 or 1'bz only
send_req  input  1  one-cycle request; sampled only in IDLE
send_data  input  8  command byte; latched on an accepted send_req
busy  output  1  high from acceptance until done
tx_active  output  1  same as busy; receiver-inhibit hint
done  output  1  one-cycle pulse at the end of every accepted transfer
err_code  output  2  valid while done=1: 00 ACK ok, 01 NACK (DAT high at ACK), 10 timeout

Behaviour:
- Pin drivers: registered clk_low and dat_low flags. PS2_CLK = clk_low ? 0 : z; PS2_DAT = dat_low ? 0 : z. Both flags reset to 0, so the lines release immediately on an asynchronous reset.
- Inputs: each pin passes through a 2-FF synchronizer. A falling edge (fe) is prev_sync & ~sync, one cycle wide.
- Reset values: state=IDLE, busy=0, done=0, err_code=00, all counters 0.
- Frame register: {stop=1, parity, data[7:0]}, shifted out LSB first. parity = ~^send_data (odd parity).
- Counters: one timer wide enough for max(all parameters), 20 bits at the defaults. Bit counter is 4 bits.
- IDLE: both lines released.
  - On send_req, latch the frame, clear the timer and go to INHIBIT.
  - busy rises on the next cycle.
- INHIBIT: clk_low=1, dat_low=0. When the timer reaches INHIBIT_CYCLES-1, go to RTS and clear the timer.
- RTS: clk_low=1, dat_low=1 (start bit). After SETUP_CYCLES, set clk_low=0, go to WAIT_FIRST and clear the timer.
- WAIT_FIRST: dat_low stays 1.
  - On fe, put frame[0] on the line (dat_low = ~frame[0]), shift the frame, set bit_cnt=1, clear the timer and go to SEND.
  - If the timer reaches START_TIMEOUT, take the timeout exit.
- SEND: on each fe, drive the next frame bit and increment bit_cnt.
  - The fe that outputs the stop bit (bit_cnt becomes 10) releases DAT and moves to ACK.
  - The timer runs continuously from the first fe. Reaching PKT_TIMEOUT takes the timeout exit.
- ACK: on fe (11th edge), sample synced DAT. 0 sets err=00, 1 sets err=01. Go to RELEASE. The packet timer still applies.
- RELEASE: wait until synced CLK and DAT are both 1. Then pulse done with the held err_code, deassert busy and return to IDLE. The packet timer still applies here; on expiry, use err=10.
- Timeout exit: both lines released, done pulses with err_code=10, return to IDLE.
- send_req while busy: ignored, with no queuing and no effect on the current transfer.
- send_req in the same cycle as a done pulse: ignored. A request is accepted only when state==IDLE.
- Reset mid-transfer: lines release within 0 cycles (asynchronous). No done pulse. The next request starts a fresh full sequence.
- The block never drives a line high. The receiver's view of PS2_CLK during INHIBIT/RTS is undefined, which is why tx_active is provided.

Test Plan:
- Small parameters (INHIBIT=50, SETUP=10, START_TO=400, PKT_TO=2000) and a device BFM clocking at a 40-cycle period. send_data=0xED -> CLK low for 50 cycles, then DAT low with CLK released. BFM samples LSB-first bits 1,0,1,1,0,1,1,1, parity=1, stop=1; BFM ACKs low -> done pulse with err_code=00, busy falls in the same cycle.
- send_data=0xF4 -> BFM samples data 0,0,1,0,1,1,1,1 and parity=0. BFM leaves DAT high on the 11th clock -> done with err_code=01.
- BFM never clocks after the CLK release -> done exactly START_TIMEOUT cycles later with err_code=10, PS2_CLK and PS2_DAT both z.
- BFM stops clocking after 4 bits -> done with err_code=10 once PKT_TIMEOUT has elapsed since the first fe, lines released.
- Second send_req=0x55 pulsed mid-transfer of 0xED -> BFM receives only 0xED, exactly one done pulse.
- Resetn low during SEND -> both lines z in the same cycle, busy=0, no done pulse. A later send_req=0xFF completes with err_code=00.
